hash_digest_reader: RTL and testbench

- Reader-side counterpart to the per-word hash-state accumulators (H0..H7).
- After the final block of a hash, it captures the 256-bit digest those registers produce.
- It scores the digest against a leading-zero difficulty target, then streams the digest out as eight 32-bit words over a valid/ready handshake to the result/reporting logic.
- It is the only consumer of the accumulator outputs in the miner datapath.

---
 rtl/hash_digest_reader.sv | 112 +++++++++++
 tb/tb_hash_digest_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hash_digest_reader.sv
// rtl/hash_digest_reader.sv - captures a final hash digest, scores leading zeros, streams it as eight words
module hash_digest_reader #(
  parameter bit BYTE_SWAP = 1'b0,
  parameter int LZ_W      = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cap_valid,
  input  logic [255:0]    digest_in,
  input  logic [LZ_W-1:0] target_zeros,
  output logic [31:0]     out_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [LZ_W-1:0] lz_count,
  output logic            hit,
  output logic            busy,
  output logic            drop_err
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [2:0]      r_idx;
  logic [255:0]    r_digest;
  logic [LZ_W-1:0] r_target;
  logic [LZ_W-1:0] r_lz;
  logic            r_hit;
  logic            r_drop;

  logic            w_capture;
  logic            w_xfer;
  logic            w_drop;
  logic [LZ_W-1:0] w_lz;
  logic            w_found;
  logic [255:0]    w_shifted;
  logic [31:0]     w_raw;

  // Leading-zero count of the incoming digest, 256 when it is all zero.
  always_comb begin
    w_lz    = LZ_W'(256);
    w_found = 1'b0;
    for (int i = 255; i >= 0; i--) begin
      if (!w_found && digest_in[i]) begin
        w_lz    = LZ_W'(255 - i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_xfer       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (cap_valid) begin
          w_capture    = 1'b1;
          w_next_state = SEND;
        end
      end
      SEND: begin
        w_drop = cap_valid;
        if (out_ready) begin
          w_xfer = 1'b1;
          if (r_idx == 3'd7) w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= 3'd0;
      r_digest <= '0;
      r_target <= '0;
      r_lz     <= '0;
      r_hit    <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_digest <= digest_in;
        r_target <= target_zeros;
        r_lz     <= w_lz;
        r_hit    <= (w_lz >= target_zeros);
        r_idx    <= 3'd0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 3'd1;
      end
      if (w_drop) r_drop <= 1'b1;
    end
  end

  // H0 sits in the top bits, so shifting left by 32*index brings word[index] to the top.
  assign w_shifted = r_digest << {r_idx, 5'b0};
  assign w_raw     = w_shifted[255:224];

  assign out_word  = (r_state != SEND) ? 32'h0 :
                     BYTE_SWAP ? {w_raw[7:0], w_raw[15:8], w_raw[23:16], w_raw[31:24]} : w_raw;
  assign out_valid = (r_state == SEND);
  assign busy      = (r_state == SEND);
  assign out_last  = (r_state == SEND) && (r_idx == 3'd7);
  assign lz_count  = r_lz;
  assign hit       = r_hit;
  assign drop_err  = r_drop;

endmodule

// File: tb/tb_hash_digest_reader.sv
// tb/tb_hash_digest_reader.sv - directed vector bench for hash_digest_reader
module tb_hash_digest_reader;

  localparam int LZ_W = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cap_valid = 1'b0;
  logic [255:0]    digest_in = '0;
  logic [LZ_W-1:0] target_zeros = '0;
  logic            out_ready = 1'b0;

  logic [31:0]     out_word, sw_word;
  logic            out_valid, out_last, hit, busy, drop_err;
  logic            sw_valid, sw_last, sw_hit, sw_busy, sw_drop;
  logic [LZ_W-1:0] lz_count, sw_lz;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hash_digest_reader #(.BYTE_SWAP(1'b0), .LZ_W(LZ_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .digest_in(digest_in),
    .target_zeros(target_zeros), .out_word(out_word), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .lz_count(lz_count), .hit(hit),
    .busy(busy), .drop_err(drop_err)
  );

  hash_digest_reader #(.BYTE_SWAP(1'b1), .LZ_W(LZ_W)) u_dut_sw (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .digest_in(digest_in),
    .target_zeros(target_zeros), .out_word(sw_word), .out_valid(sw_valid),
    .out_ready(out_ready), .out_last(sw_last), .lz_count(sw_lz), .hit(sw_hit),
    .busy(sw_busy), .drop_err(sw_drop)
  );

  typedef struct {
    logic [255:0]    d;
    logic [LZ_W-1:0] t;
    logic [LZ_W-1:0] lz;
    logic            hit;
    logic [31:0]     sw0;
  } vec_t;

  vec_t vecs[8];

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hword(input logic [255:0] d, input int k);
    return d[255 - 32*k -: 32];
  endfunction

  task automatic capture(input logic [255:0] d, input logic [LZ_W-1:0] t);
    @(negedge clk);
    digest_in    = d;
    target_zeros = t;
    cap_valid    = 1'b1;
    @(negedge clk);
    cap_valid    = 1'b0;
  endtask

  task automatic chk_word(input string name, input logic [255:0] d, input int k);
    chk(name, {out_valid, out_last, out_word}, {1'b1, (k == 7), hword(d, k)});
  endtask

  initial begin
    vecs[0] = '{IV, 9'd1, 9'd1, 1'b1, 32'h67e6096a};
    vecs[1] = '{{32'h0, 32'h0000ffff, {6{32'hffffffff}}}, 9'd48, 9'd48, 1'b1, 32'h0};
    vecs[2] = '{{32'h0, 32'h0000ffff, {6{32'hffffffff}}}, 9'd49, 9'd48, 1'b0, 32'h0};
    vecs[3] = '{256'h0, 9'd256, 9'd256, 1'b1, 32'h0};
    vecs[4] = '{256'h0, 9'd0, 9'd256, 1'b1, 32'h0};
    vecs[5] = '{{32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab,
                 32'h5be0cd19, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372}, 9'd300, 9'd0, 1'b0, 32'h3af54fa5};
    vecs[6] = '{{256{1'b1}}, 9'd0, 9'd0, 1'b1, 32'hffffffff};
    vecs[7] = '{{32'h00000001, {7{32'hffffffff}}}, 9'd32, 9'd31, 1'b0, 32'h01000000};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {out_word, out_valid, out_last, lz_count, hit, busy, drop_err}, '0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_no_valid", {out_valid, busy}, 2'b00);

    for (int i = 0; i < 8; i++) begin
      capture(vecs[i].d, vecs[i].t);
      chk($sformatf("v%0d_lz", i), lz_count, vecs[i].lz);
      chk($sformatf("v%0d_hit", i), hit, vecs[i].hit);
      chk($sformatf("v%0d_busy", i), busy, 1'b1);
      chk($sformatf("v%0d_swap_w0", i), sw_word, vecs[i].sw0);
      for (int k = 0; k < 8; k++) begin
        chk_word($sformatf("v%0d_w%0d", i, k), vecs[i].d, k);
        @(negedge clk);
      end
      chk($sformatf("v%0d_done", i), {out_valid, busy, out_last}, 3'b000);
    end
    chk("no_drop_yet", drop_err, 1'b0);

    // Backpressure: stall five cycles with H3 presented.
    capture(IV, 9'd1);
    for (int k = 0; k < 3; k++) begin
      chk_word($sformatf("bp_w%0d", k), IV, k);
      @(negedge clk);
    end
    chk_word("bp_w3", IV, 3);
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk_word($sformatf("bp_hold%0d", s), IV, 3);
    end
    out_ready = 1'b1;
    for (int k = 4; k < 8; k++) begin
      @(negedge clk);
      chk_word($sformatf("bp_w%0d", k), IV, k);
    end
    @(negedge clk);
    chk("bp_done", {out_valid, busy}, 2'b00);

    // Captures during SEND, including one on the final transfer edge, are dropped.
    capture(IV, 9'd1);
    for (int k = 0; k < 8; k++) begin
      chk_word($sformatf("drop_w%0d", k), IV, k);
      if (k == 2 || k == 7) begin
        digest_in    = {256{1'b1}};
        target_zeros = 9'd0;
        cap_valid    = 1'b1;
      end
      @(negedge clk);
      cap_valid = 1'b0;
    end
    chk("drop_idle", {out_valid, busy}, 2'b00);
    chk("drop_kept_score", {lz_count, hit}, {9'd1, 1'b1});
    chk("drop_err_set", drop_err, 1'b1);
    repeat (3) @(negedge clk);
    chk("drop_err_sticky", {drop_err, out_valid}, 2'b10);

    // Asynchronous reset mid-stream at index 4.
    capture(256'h0, 9'd256);
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk_word("rst_w4", 256'h0, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async", {out_valid, busy, lz_count, hit, drop_err, out_word}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    capture(IV, 9'd2);
    chk_word("restart_w0", IV, 0);
    chk("restart_score", {lz_count, hit}, {9'd1, 1'b0});
    repeat (8) @(negedge clk);
    chk("restart_done", {out_valid, drop_err}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
